// File: rtl/risc_mc_core.sv
// Multi-cycle RISC core: handshake decode, register memory, ALU and writeback
// sequenced by one FSM (IDLE -> RD_A -> [RD_B] -> EXEC -> WB).
module risc_mc_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] operand_1,
    input  logic [IMM_W-1:0]  operand_2,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              cb,
    output logic              zero,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ADC  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDR = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_LD   = 4'hD;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    state_t state_r, next_state_s;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [3:0]        op_r;
    logic [ADDR_W-1:0] rd_r;
    logic [IMM_W-1:0]  op2_r;
    logic              cin_r;
    logic [DATA_W-1:0] a_r, b_r;
    logic [DATA_W-1:0] result_r;
    logic              result_valid_r, cb_r, zero_r, err_r, ready_r;

    logic              accept_s, reserved_s, start_s, reg_op_s, writes_s;
    logic [ADDR_W-1:0] rs_s;
    logic [DATA_W-1:0] imm_s, b_sel_s, alu_res_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic              alu_cb_s, cb_upd_s;

    assign accept_s   = instr_valid && ready_r;
    assign reserved_s = (opcode == 4'hE) || (opcode == 4'hF);
    assign start_s    = accept_s && !reserved_s && (opcode != OP_NOP);
    assign reg_op_s   = (op_r == OP_ADDR) || (op_r == OP_MOV);
    assign writes_s   = (op_r != OP_CMP) && (op_r != OP_LD);
    assign rs_s       = op2_r[ADDR_W-1:0];
    assign imm_s      = DATA_W'($signed(op2_r));
    assign b_sel_s    = reg_op_s ? b_r : imm_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing; the RD_B step exists only for register-source ops
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = start_s ? RD_A : IDLE;
            RD_A:    next_state_s = reg_op_s ? RD_B : EXEC;
            RD_B:    next_state_s = EXEC;
            EXEC:    next_state_s = WB;
            WB:      next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // ALU: arithmetic is one bit wider so carry/borrow fall out of the top bit
    always_comb begin
        sum_s     = {1'b0, a_r} + {1'b0, b_sel_s}
                  + {{DATA_W{1'b0}}, cin_r & (op_r == OP_ADC)};
        diff_s    = {1'b0, a_r} - {1'b0, b_sel_s};
        alu_res_s = {DATA_W{1'b0}};
        alu_cb_s  = 1'b0;
        cb_upd_s  = 1'b0;
        case (op_r)
            OP_LDI: alu_res_s = imm_s;
            OP_ADD, OP_ADC, OP_ADDR: begin
                alu_res_s = sum_s[DATA_W-1:0];
                alu_cb_s  = sum_s[DATA_W];
                cb_upd_s  = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res_s = diff_s[DATA_W-1:0];
                alu_cb_s  = diff_s[DATA_W];
                cb_upd_s  = 1'b1;
            end
            OP_AND:  alu_res_s = a_r & imm_s;
            OP_OR:   alu_res_s = a_r | imm_s;
            OP_XOR:  alu_res_s = a_r ^ imm_s;
            OP_SHL:  alu_res_s = a_r << imm_s[SH_W-1:0];
            OP_SHR:  alu_res_s = a_r >> imm_s[SH_W-1:0];
            OP_MOV:  alu_res_s = b_r;
            OP_LD:   alu_res_s = a_r;
            default: alu_res_s = {DATA_W{1'b0}};
        endcase
    end

    // Instruction latch, operand fetch, result/flag registers and writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            op_r           <= 4'h0;
            rd_r           <= {ADDR_W{1'b0}};
            op2_r          <= {IMM_W{1'b0}};
            cin_r          <= 1'b0;
            a_r            <= {DATA_W{1'b0}};
            b_r            <= {DATA_W{1'b0}};
            result_r       <= {DATA_W{1'b0}};
            result_valid_r <= 1'b0;
            cb_r           <= 1'b0;
            zero_r         <= 1'b0;
            err_r          <= 1'b0;
            ready_r        <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            err_r          <= accept_s && reserved_s;
            ready_r        <= (next_state_s == IDLE);
            if (start_s) begin
                op_r  <= opcode;
                rd_r  <= operand_1;
                op2_r <= operand_2;
                cin_r <= cin;
            end
            case (state_r)
                RD_A: a_r <= mem_r[rd_r];
                RD_B: b_r <= mem_r[rs_s];
                EXEC: begin
                    result_r       <= alu_res_s;
                    zero_r         <= (alu_res_s == {DATA_W{1'b0}});
                    result_valid_r <= 1'b1;
                    if (cb_upd_s) begin
                        cb_r <= alu_cb_s;
                    end
                end
                WB: begin
                    if (writes_s) begin
                        mem_r[rd_r] <= result_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready  = ready_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign cb           = cb_r;
    assign zero         = zero_r;
    assign err          = err_r;

endmodule

// File: tb/tb_risc_mc_core.sv
// Directed self-checking bench for risc_mc_core with hand-computed expectations.
module tb_risc_mc_core;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [3:0]  operand_1;
    logic [7:0]  operand_2;
    logic        cin;
    logic [15:0] result;
    logic        result_valid;
    logic        cb;
    logic        zero;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    risc_mc_core #(.DATA_W(16), .ADDR_W(4), .IMM_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .operand_1    (operand_1),
        .operand_2    (operand_2),
        .cin          (cin),
        .result       (result),
        .result_valid (result_valid),
        .cb           (cb),
        .zero         (zero),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for instr_ready, presents one instruction for the accept edge.
    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm,
                        input logic c);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!instr_ready) check_value("ready_timeout", {31'b0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        opcode      = op;
        operand_1   = rd;
        operand_2   = imm;
        cin         = c;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        cin         = 1'b0;
        opcode      = 4'h0;
    endtask

    // Issues an op and counts edges after the accept edge until result_valid.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] rd,
                          input logic [7:0] imm, input logic c, input int exp_lat);
        int lat = 0;
        send(op, rd, imm, c);
        while (!result_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check_value({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int rv_cnt;
        rst = 1'b0; instr_valid = 1'b0; opcode = 4'h0;
        operand_1 = 4'h0; operand_2 = 8'h00; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ready", {31'b0, instr_ready}, 32'd0);
        check_value("rst_result", {16'b0, result}, 32'h0);
        check_value("rst_flags", {28'b0, result_valid, cb, zero, err}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_value("ready_after_rst", {31'b0, instr_ready}, 32'd1);

        run_op("ldi_r2", 4'h1, 4'd2, 8'h80, 1'b0, 2);
        check_value("ldi_r2_res", {16'b0, result}, 32'hFF80);
        run_op("ld_r2", 4'hD, 4'd2, 8'h00, 1'b0, 2);
        check_value("ld_r2_res", {16'b0, result}, 32'hFF80);

        // Held instr_valid: accepts at E0, E4, E8 -> pulses after E2 and E6 only
        while (!instr_ready) begin @(posedge clk); #1; end
        instr_valid = 1'b1; opcode = 4'hD; operand_1 = 4'd2; operand_2 = 8'h00;
        @(posedge clk); #1;
        rv_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (result_valid) rv_cnt++;
        end
        instr_valid = 1'b0; opcode = 4'h0;
        check_value("held_valid_pulses", rv_cnt, 32'd2);

        run_op("ldi_r1", 4'h1, 4'd1, 8'hFF, 1'b0, 2);
        check_value("ldi_r1_res", {16'b0, result}, 32'hFFFF);
        run_op("add_r1", 4'h2, 4'd1, 8'h01, 1'b0, 2);
        check_value("add_res", {16'b0, result}, 32'h0000);
        check_value("add_cb_z", {30'b0, cb, zero}, 32'h3);
        run_op("ld_r1", 4'hD, 4'd1, 8'h00, 1'b0, 2);
        check_value("ld_keeps_cb", {30'b0, cb, zero}, 32'h3);
        run_op("adc_r1", 4'h3, 4'd1, 8'h00, 1'b1, 2);
        check_value("adc_res", {16'b0, result}, 32'h0001);
        check_value("adc_cb_z", {30'b0, cb, zero}, 32'h0);

        run_op("ldi_r4", 4'h1, 4'd4, 8'h05, 1'b0, 2);
        run_op("sub_r4", 4'h4, 4'd4, 8'h06, 1'b0, 2);
        check_value("sub_res", {16'b0, result}, 32'hFFFF);
        check_value("sub_cb_z", {30'b0, cb, zero}, 32'h2);
        run_op("cmp_r4", 4'hC, 4'd4, 8'h7F, 1'b0, 2);
        check_value("cmp_cb_z", {30'b0, cb, zero}, 32'h0);
        run_op("ld_r4", 4'hD, 4'd4, 8'h00, 1'b0, 2);
        check_value("ld_r4_res", {16'b0, result}, 32'hFFFF);

        run_op("ldi_r5", 4'h1, 4'd5, 8'h03, 1'b0, 2);
        run_op("ldi_r6", 4'h1, 4'd6, 8'h04, 1'b0, 2);
        run_op("addr_r5", 4'hA, 4'd5, 8'h06, 1'b0, 3);
        check_value("addr_res", {16'b0, result}, 32'h0007);
        run_op("mov_r7", 4'hB, 4'd7, 8'h05, 1'b0, 3);
        run_op("ld_r7", 4'hD, 4'd7, 8'h00, 1'b0, 2);
        check_value("mov_r7_res", {16'b0, result}, 32'h0007);
        run_op("addr_r7r7", 4'hA, 4'd7, 8'h07, 1'b0, 3);
        check_value("addr_double", {16'b0, result}, 32'h000E);
        run_op("shr_r7", 4'h9, 4'd7, 8'h01, 1'b0, 2);
        check_value("shr_res", {16'b0, result}, 32'h0007);
        run_op("shl_r7", 4'h8, 4'd7, 8'h04, 1'b0, 2);
        check_value("shl_res", {16'b0, result}, 32'h0070);
        run_op("xor_r7", 4'h7, 4'd7, 8'hFF, 1'b0, 2);
        check_value("xor_res", {16'b0, result}, 32'hFF8F);
        run_op("add_r5", 4'h2, 4'd5, 8'hFF, 1'b0, 2);
        check_value("add_r5_res", {16'b0, result}, 32'h0006);
        check_value("add_r5_cb", {31'b0, cb}, 32'd1);

        send(4'hE, 4'd1, 8'h01, 1'b0);
        check_value("rsv_err", {31'b0, err}, 32'd1);
        check_value("rsv_ready", {31'b0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        check_value("rsv_err_pulse", {31'b0, err}, 32'd0);
        check_value("rsv_keeps", {15'b0, cb, result}, 32'h10006);
        send(4'h0, 4'd1, 8'h01, 1'b0);
        check_value("nop_err", {30'b0, err, instr_ready}, 32'h1);

        // Abort: reset lands while the ADD sits in EXEC
        send(4'h2, 4'd1, 8'h01, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check_value("abort_outs", {12'b0, result, result_valid, cb, zero, err}, 32'h0);
        check_value("abort_ready", {31'b0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (result_valid) rv_cnt++;
        end
        check_value("abort_no_rv", rv_cnt, 32'd0);
        run_op("ld_r1_post", 4'hD, 4'd1, 8'h00, 1'b0, 2);
        check_value("r1_after_abort", {16'b0, result}, 32'h0000);
        run_op("ld_r2_post", 4'hD, 4'd2, 8'h00, 1'b0, 2);
        check_value("r2_cleared", {14'b0, cb, zero, result}, 32'h10000);
        run_op("ld_r3", 4'hD, 4'd3, 8'h00, 1'b0, 2);
        check_value("ld_r3_flags", {14'b0, cb, zero, result}, 32'h10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
